// File: rtl/tlc_phase_monitor.sv
// tlc_phase_monitor
//
// Passive observer on the traffic light controller's lamp outputs. Registers the
// car and pedestrian lamp lines, de-glitches them with a stability filter, decodes
// the car phase, and checks for car/ped conflicts, illegal lamp patterns, bad phase
// sequencing, short amber phases and phase timeouts. The first fault is latched
// until cleared.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   car_lamps    {red, yellow, green} from the controller
//   ped_lamps    {red, green} from the controller
//   clear        clears the latched fault
//   phase        accepted car phase (0 OFF, 1 RED, 2 RED_YELLOW, 3 GREEN, 4 YELLOW, 7 UNKNOWN)
//   phase_secs   whole seconds in the current phase, saturating at 255
//   cycle_count  completed YELLOW->RED transitions, wrapping
//   fault        sticky fault flag
//   fault_code   code of the first latched fault

module tlc_phase_monitor #(
    parameter int unsigned CLK_HZ      = 1000,
    parameter int unsigned FILTER_CYC  = 4,
    parameter int unsigned MIN_AMBER_S = 1,
    parameter int unsigned MAX_PHASE_S = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] car_lamps,
    input  logic [1:0] ped_lamps,
    input  logic       clear,
    output logic [2:0] phase,
    output logic [7:0] phase_secs,
    output logic [7:0] cycle_count,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [2:0] PH_OFF     = 3'd0;
    localparam logic [2:0] PH_RED     = 3'd1;
    localparam logic [2:0] PH_RED_YEL = 3'd2;
    localparam logic [2:0] PH_GREEN   = 3'd3;
    localparam logic [2:0] PH_YELLOW  = 3'd4;
    localparam logic [2:0] PH_UNKNOWN = 3'd7;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_ILLEGAL  = 3'd2;
    localparam logic [2:0] FC_BAD_SEQ  = 3'd3;
    localparam logic [2:0] FC_SHORT    = 3'd4;
    localparam logic [2:0] FC_TIMEOUT  = 3'd5;

    localparam int unsigned CNT_W = $clog2(FILTER_CYC + 1);
    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_CYC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [7:0]       MAX_SECS = 8'(MAX_PHASE_S);
    localparam logic [7:0]       MIN_SECS = 8'(MIN_AMBER_S);

    // {car r, car y, car g, ped r, ped g}
    logic [4:0]       sample_q;
    logic             sample_vld_q;
    logic [4:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       acc_q;
    logic             acc_vld_q;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [2:0]       phase_q, phase_d;
    logic [7:0]       secs_q, secs_d;
    logic [7:0]       cyc_cnt_q, cyc_cnt_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;

    logic       accept;
    logic       car_r, car_y, car_g, ped_r, ped_g;
    logic       conflict, illegal, seq_ok, short_amber, changes, moving, timeout;
    logic [2:0] new_phase;
    logic [2:0] acc_code, raise_code;

    always_comb begin
        // Stability filter; held until the capture register holds a real sample.
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sample_vld_q) begin
            if (sample_q != cand_q) begin
                cand_d = sample_q;
                cnt_d  = CNT_W'(1);
            end else if (cnt_q != FILT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Accepted pattern tracks cand_d, so each new pattern yields one pulse.
        accept = (cnt_d == FILT_MAX) && (!acc_vld_q || (cand_d != acc_q));

        {car_r, car_y, car_g, ped_r, ped_g} = cand_d;

        conflict = ped_g && (car_g || car_y);
        // r+g also covers all three lit.
        illegal  = (car_r && car_g) || (car_y && car_g) || (ped_r && ped_g);

        case (cand_d[4:2])
            3'b000:  new_phase = PH_OFF;
            3'b100:  new_phase = PH_RED;
            3'b110:  new_phase = PH_RED_YEL;
            3'b001:  new_phase = PH_GREEN;
            3'b010:  new_phase = PH_YELLOW;
            default: new_phase = PH_UNKNOWN;
        endcase

        if (new_phase == PH_OFF) begin
            seq_ok = 1'b1;
        end else begin
            case (phase_q)
                PH_UNKNOWN: seq_ok = 1'b1;
                PH_OFF:     seq_ok = (new_phase == PH_RED);
                PH_RED:     seq_ok = (new_phase == PH_RED_YEL);
                PH_RED_YEL: seq_ok = (new_phase == PH_GREEN);
                PH_GREEN:   seq_ok = (new_phase == PH_YELLOW);
                PH_YELLOW:  seq_ok = (new_phase == PH_RED);
                default:    seq_ok = 1'b0;
            endcase
        end

        short_amber = ((phase_q == PH_YELLOW) || (phase_q == PH_RED_YEL)) && (secs_q < MIN_SECS);
        // Same car phase means a ped-only change: legal, timers keep running.
        changes     = (new_phase != phase_q);
        moving      = accept && !conflict && !illegal && changes;

        acc_code = FC_NONE;
        if (accept) begin
            if (conflict)                    acc_code = FC_CONFLICT;
            else if (illegal)                acc_code = FC_ILLEGAL;
            else if (changes && !seq_ok)     acc_code = FC_BAD_SEQ;
            else if (changes && short_amber) acc_code = FC_SHORT;
        end

        // Seconds prescaler and phase timer.
        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            secs_d  = (secs_q == 8'hff) ? secs_q : secs_q + 8'd1;
        end else begin
            presc_d = presc_q + PRE_W'(1);
            secs_d  = secs_q;
        end

        phase_d   = phase_q;
        cyc_cnt_d = cyc_cnt_q;
        if (moving) begin
            phase_d = new_phase;
            presc_d = '0;
            secs_d  = 8'd0;
            if ((phase_q == PH_YELLOW) && (new_phase == PH_RED)) begin
                cyc_cnt_d = cyc_cnt_q + 8'd1;
            end
        end

        // Fires only on the edge the timer arrives at the limit: once per phase entry.
        timeout = !moving && (phase_q != PH_OFF) && (phase_q != PH_UNKNOWN) &&
                  (secs_q != MAX_SECS) && (secs_d == MAX_SECS);

        raise_code = (acc_code != FC_NONE) ? acc_code : (timeout ? FC_TIMEOUT : FC_NONE);

        fault_d = fault_q;
        code_d  = code_q;
        if (clear) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end
        // A fault raised alongside clear still latches.
        if ((raise_code != FC_NONE) && (!fault_q || clear)) begin
            fault_d = 1'b1;
            code_d  = raise_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            cand_q       <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            acc_vld_q    <= 1'b0;
            presc_q      <= '0;
            phase_q      <= PH_UNKNOWN;
            secs_q       <= 8'd0;
            cyc_cnt_q    <= 8'd0;
            fault_q      <= 1'b0;
            code_q       <= FC_NONE;
        end else begin
            sample_q     <= {car_lamps, ped_lamps};
            sample_vld_q <= 1'b1;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            if (accept) begin
                acc_q     <= cand_d;
                acc_vld_q <= 1'b1;
            end
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            secs_q    <= secs_d;
            cyc_cnt_q <= cyc_cnt_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
        end
    end

    assign phase       = phase_q;
    assign phase_secs  = secs_q;
    assign cycle_count = cyc_cnt_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;

endmodule

// File: tb/tb_tlc_phase_monitor.sv
// Testbench for tlc_phase_monitor. Stimulus pushes expected output records keyed
// by cycle number; a monitor pops and compares them at that cycle, and flags any
// output change that no record predicted.

module tb_tlc_phase_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] car_lamps;
    logic [1:0] ped_lamps;
    logic       clear;
    logic [2:0] phase;
    logic [7:0] phase_secs;
    logic [7:0] cycle_count;
    logic       fault;
    logic [2:0] fault_code;

    tlc_phase_monitor #(
        .CLK_HZ      (10),
        .FILTER_CYC  (4),
        .MIN_AMBER_S (1),
        .MAX_PHASE_S (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .car_lamps   (car_lamps),
        .ped_lamps   (ped_lamps),
        .clear       (clear),
        .phase       (phase),
        .phase_secs  (phase_secs),
        .cycle_count (cycle_count),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    // cyc == N at the negedge following posedge N.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at_cyc;
        string       tag;
        logic [2:0]  ph;
        logic [7:0]  secs;
        logic [7:0]  cc;
        logic        flt;
        logic [2:0]  code;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_at(input int unsigned at, input string tag, input int ph,
                             input int secs, input int cc, input int flt, input int code);
        exp_t e;
        e.at_cyc = at;
        e.tag    = tag;
        e.ph     = 3'(ph);
        e.secs   = 8'(secs);
        e.cc     = 8'(cc);
        e.flt    = 1'(flt);
        e.code   = 3'(code);
        exp_q.push_back(e);
    endtask

    task automatic goto(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic lamps(input logic [2:0] c, input logic [1:0] p);
        car_lamps = c;
        ped_lamps = p;
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        logic [14:0] prev_snap;
        logic [14:0] snap;
        exp_t        e;
        prev_snap = '0;
        forever begin
            @(negedge clk);
            snap = {phase, cycle_count, fault, fault_code};
            while (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL %s: record for cyc %0d never compared (now cyc %0d)",
                         e.tag, e.at_cyc, cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].at_cyc == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                if (phase !== e.ph || phase_secs !== e.secs || cycle_count !== e.cc ||
                    fault !== e.flt || fault_code !== e.code) begin
                    n_fail++;
                    $display({"FAIL %s @cyc %0d: got phase=%0d secs=%0d cycles=%0d fault=%0d ",
                              "code=%0d, want phase=%0d secs=%0d cycles=%0d fault=%0d code=%0d"},
                             e.tag, cyc, phase, phase_secs, cycle_count, fault, fault_code,
                             e.ph, e.secs, e.cc, e.flt, e.code);
                end
            end else if (cyc > 2) begin
                n_checks++;
                if (snap !== prev_snap) begin
                    n_fail++;
                    $display({"FAIL stable @cyc %0d: got phase=%0d cycles=%0d fault=%0d code=%0d, ",
                              "want unchanged (phase/cycles/fault/code was %h)"},
                             cyc, phase, cycle_count, fault, fault_code, prev_snap);
                end
            end
            prev_snap = snap;
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not reach the end by cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst   = 1'b1;
        clear = 1'b0;
        lamps(3'b100, 2'b01);
        expect_at(2, "reset", 7, 0, 0, 0, 0);
        goto(2);
        rst = 1'b0;
        expect_at(7, "first_red", 1, 0, 0, 0, 0);

        // Legal loop, 30 cycles per phase.
        goto(32);  lamps(3'b110, 2'b10); expect_at(37, "red_yel", 2, 0, 0, 0, 0);
        goto(62);  lamps(3'b001, 2'b10); expect_at(67, "green", 3, 0, 0, 0, 0);
        // Three-cycle dark glitch must not be accepted.
        goto(92);  lamps(3'b000, 2'b10);
        goto(95);  lamps(3'b001, 2'b10); expect_at(100, "glitch_ignored", 3, 3, 0, 0, 0);
        goto(110); lamps(3'b010, 2'b10); expect_at(115, "yellow", 4, 0, 0, 0, 0);
        goto(145); lamps(3'b100, 2'b10); expect_at(150, "red_cycle", 1, 0, 1, 0, 0);

        // Timeout after 20 s in RED, then clear.
        goto(150); expect_at(350, "timeout", 1, 20, 1, 1, 5);
        goto(355); clear = 1'b1; expect_at(356, "clear_timeout", 1, 20, 1, 0, 0);
        goto(356); clear = 1'b0;

        // Ped-only change keeps the timer running; then conflict.
        goto(360); lamps(3'b100, 2'b01); expect_at(365, "ped_only", 1, 21, 1, 0, 0);
        goto(370); lamps(3'b001, 2'b01); expect_at(375, "conflict", 1, 22, 1, 1, 1);
        goto(380); lamps(3'b010, 2'b10); expect_at(385, "bad_seq_no_overwrite", 4, 0, 1, 1, 1);

        // Short RED_YELLOW.
        goto(390); clear = 1'b1; expect_at(391, "clear_conflict", 4, 0, 1, 0, 0);
        goto(391); clear = 1'b0;
        goto(395); lamps(3'b100, 2'b10); expect_at(400, "red_again", 1, 0, 2, 0, 0);
        goto(410); lamps(3'b110, 2'b10); expect_at(415, "red_yel_short", 2, 0, 2, 0, 0);
        goto(415); lamps(3'b001, 2'b10); expect_at(420, "short_phase", 3, 0, 2, 1, 4);

        // Illegal lamp pattern leaves phase alone.
        goto(425); clear = 1'b1; expect_at(426, "clear_short", 3, 0, 2, 0, 0);
        goto(426); clear = 1'b0;
        goto(430); lamps(3'b101, 2'b10); expect_at(435, "illegal_lamp", 3, 1, 2, 1, 2);

        // BAD_SEQ lands on the same edge as clear.
        goto(440); lamps(3'b100, 2'b10);
        goto(444); clear = 1'b1; expect_at(445, "clear_with_bad_seq", 1, 0, 2, 1, 3);
        goto(445); clear = 1'b0;

        // Reset in the middle of YELLOW.
        goto(450); clear = 1'b1; expect_at(451, "clear_bad_seq", 1, 0, 2, 0, 0);
        goto(451); clear = 1'b0;
        goto(455); lamps(3'b110, 2'b10); expect_at(460, "red_yel_2", 2, 0, 2, 0, 0);
        goto(495); lamps(3'b001, 2'b10); expect_at(500, "green_2", 3, 0, 2, 0, 0);
        goto(510); lamps(3'b010, 2'b10); expect_at(515, "yellow_2", 4, 0, 2, 0, 0);
        goto(530); rst = 1'b1; expect_at(531, "mid_reset", 7, 0, 0, 0, 0);
        goto(532); rst = 1'b0; expect_at(537, "from_unknown", 4, 0, 0, 0, 0);

        goto(560);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d uncompared records, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
